// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: issue/writeback scheduler between the core and five fixed-latency FPU units.
// Accepts one op per cycle (valid/ready), strobes the selected unit and books the single
// writeback slot at the cycle the result will appear, so two units never return together.
// Ports:
//   clk, rstn                      clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready            request handshake; req_ready does not depend on req_valid
//   req_op, req_tag, req_a, req_b  op (0 ITOF,1 FTOI,2 FADD,3 FMUL,4 FDIV,5..7 illegal), tag, operands
//   u_a, u_b                       operands forwarded to the units
//   *_start                        one-cycle unit strobes
//   *_res                          unit results, valid exactly LAT_* cycles after the strobe
//   res_valid/res_tag/res_data/res_err  registered result pulse, tag, data, illegal-op flag
//   busy                           any op in flight or result pending
module fpu_issue_ctrl #(
  parameter int unsigned TAG_W    = 4,
  parameter int unsigned LAT_ITOF = 1,
  parameter int unsigned LAT_FTOI = 1,
  parameter int unsigned LAT_FADD = 2,
  parameter int unsigned LAT_FMUL = 2,
  parameter int unsigned LAT_FDIV = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [TAG_W-1:0] req_tag,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  output logic [31:0]      u_a,
  output logic [31:0]      u_b,
  output logic             itof_start,
  output logic             ftoi_start,
  output logic             fadd_start,
  output logic             fmul_start,
  output logic             fdiv_start,
  input  logic [31:0]      itof_res,
  input  logic [31:0]      ftoi_res,
  input  logic [31:0]      fadd_res,
  input  logic [31:0]      fmul_res,
  input  logic [31:0]      fdiv_res,
  output logic             res_valid,
  output logic [TAG_W-1:0] res_tag,
  output logic [31:0]      res_data,
  output logic             res_err,
  output logic             busy
);

  localparam int unsigned MAX_A = (LAT_ITOF > LAT_FTOI) ? LAT_ITOF : LAT_FTOI;
  localparam int unsigned MAX_B = (LAT_FADD > LAT_FMUL) ? LAT_FADD : LAT_FMUL;
  localparam int unsigned MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned LMAX  = (MAX_C > LAT_FDIV) ? MAX_C : LAT_FDIV;
  localparam int unsigned IDX_W = $clog2(LMAX + 1);

  localparam logic [2:0] OP_ITOF = 3'd0;
  localparam logic [2:0] OP_FTOI = 3'd1;
  localparam logic [2:0] OP_FADD = 3'd2;
  localparam logic [2:0] OP_FMUL = 3'd3;
  localparam logic [2:0] OP_FDIV = 3'd4;

  // Slot k valid: a unit result is captured k cycles from now.
  logic [LMAX:1]            resv_q, resv_d;
  logic [LMAX:1][TAG_W-1:0] slot_tag_q, slot_tag_d;
  logic [LMAX:1][2:0]       slot_op_q, slot_op_d;
  logic [LMAX:1]            slot_ill_q, slot_ill_d;
  logic                     div_busy_q, div_busy_d;
  logic                     res_valid_q, res_valid_d;
  logic [TAG_W-1:0]         res_tag_q, res_tag_d;
  logic [31:0]              res_data_q, res_data_d;
  logic                     res_err_q, res_err_d;

  logic [IDX_W-1:0] lat;
  logic             illegal;
  logic             slot_taken;
  logic             fire;
  logic [31:0]      cap_data;

  // Latency of the offered op; illegal ops take the shortest path to report the error.
  always_comb begin
    lat     = IDX_W'(1);
    illegal = 1'b0;
    case (req_op)
      OP_ITOF: lat = IDX_W'(LAT_ITOF);
      OP_FTOI: lat = IDX_W'(LAT_FTOI);
      OP_FADD: lat = IDX_W'(LAT_FADD);
      OP_FMUL: lat = IDX_W'(LAT_FMUL);
      OP_FDIV: lat = IDX_W'(LAT_FDIV);
      default: illegal = 1'b1;
    endcase
  end

  // The op would land in slot lat after this cycle's shift, i.e. today's slot lat+1.
  always_comb begin
    slot_taken = 1'b0;
    for (int unsigned k = 1; k < LMAX; k++) begin
      if (lat == IDX_W'(k)) slot_taken = resv_q[k+1];
    end
  end

  assign req_ready = !slot_taken && !(req_op == OP_FDIV && div_busy_q);
  assign fire      = req_valid && req_ready;

  // Slot shift and booking of the new op.
  always_comb begin
    resv_d     = '0;
    slot_tag_d = '0;
    slot_op_d  = '0;
    slot_ill_d = '0;
    for (int unsigned k = 1; k < LMAX; k++) begin
      resv_d[k]     = resv_q[k+1];
      slot_tag_d[k] = slot_tag_q[k+1];
      slot_op_d[k]  = slot_op_q[k+1];
      slot_ill_d[k] = slot_ill_q[k+1];
    end
    if (fire) begin
      for (int unsigned k = 1; k <= LMAX; k++) begin
        if (lat == IDX_W'(k)) begin
          resv_d[k]     = 1'b1;
          slot_tag_d[k] = req_tag;
          slot_op_d[k]  = req_op;
          slot_ill_d[k] = illegal;
        end
      end
    end
  end

  // Result capture from the unit booked in slot 1, and divider occupancy.
  always_comb begin
    case (slot_op_q[1])
      OP_ITOF: cap_data = itof_res;
      OP_FTOI: cap_data = ftoi_res;
      OP_FADD: cap_data = fadd_res;
      OP_FMUL: cap_data = fmul_res;
      OP_FDIV: cap_data = fdiv_res;
      default: cap_data = '0;
    endcase
    res_valid_d = resv_q[1];
    res_tag_d   = res_tag_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    if (resv_q[1]) begin
      res_tag_d  = slot_tag_q[1];
      res_data_d = cap_data;
      res_err_d  = slot_ill_q[1];
    end
    div_busy_d = div_busy_q;
    if (resv_q[1] && slot_op_q[1] == OP_FDIV) div_busy_d = 1'b0;
    if (fire && req_op == OP_FDIV)             div_busy_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      resv_q      <= '0;
      slot_tag_q  <= '0;
      slot_op_q   <= '0;
      slot_ill_q  <= '0;
      div_busy_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_tag_q   <= '0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
    end else begin
      resv_q      <= resv_d;
      slot_tag_q  <= slot_tag_d;
      slot_op_q   <= slot_op_d;
      slot_ill_q  <= slot_ill_d;
      div_busy_q  <= div_busy_d;
      res_valid_q <= res_valid_d;
      res_tag_q   <= res_tag_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
    end
  end

  // Outputs.
  always_comb begin
    u_a        = req_a;
    u_b        = req_b;
    itof_start = fire && (req_op == OP_ITOF);
    ftoi_start = fire && (req_op == OP_FTOI);
    fadd_start = fire && (req_op == OP_FADD);
    fmul_start = fire && (req_op == OP_FMUL);
    fdiv_start = fire && (req_op == OP_FDIV);
    res_valid  = res_valid_q;
    res_tag    = res_tag_q;
    res_data   = res_data_q;
    res_err    = res_err_q;
    busy       = (|resv_q) || div_busy_q || res_valid_q;
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl. A calendar model books each accepted op at its
// absolute capture cycle and result cycle; unit stubs answer exactly LAT cycles after a strobe
// and drive random junk otherwise.
module tb_fpu_issue_ctrl;

  localparam int unsigned TAG_W    = 4;
  localparam int unsigned LAT_ITOF = 1;
  localparam int unsigned LAT_FTOI = 1;
  localparam int unsigned LAT_FADD = 2;
  localparam int unsigned LAT_FMUL = 2;
  localparam int unsigned LAT_FDIV = 8;
  localparam int CAL = 64;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [2:0]       req_op = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic [31:0]      req_a = '0;
  logic [31:0]      req_b = '0;
  logic [31:0]      u_a, u_b;
  logic             itof_start, ftoi_start, fadd_start, fmul_start, fdiv_start;
  logic [31:0]      ures [5];
  logic             res_valid;
  logic [TAG_W-1:0] res_tag;
  logic [31:0]      res_data;
  logic             res_err;
  logic             busy;
  logic [4:0]       starts;

  assign starts = {fdiv_start, fmul_start, fadd_start, ftoi_start, itof_start};

  always #5 clk = ~clk;

  fpu_issue_ctrl #(
    .TAG_W   (TAG_W),
    .LAT_ITOF(LAT_ITOF),
    .LAT_FTOI(LAT_FTOI),
    .LAT_FADD(LAT_FADD),
    .LAT_FMUL(LAT_FMUL),
    .LAT_FDIV(LAT_FDIV)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_tag   (req_tag),
    .req_a     (req_a),
    .req_b     (req_b),
    .u_a       (u_a),
    .u_b       (u_b),
    .itof_start(itof_start),
    .ftoi_start(ftoi_start),
    .fadd_start(fadd_start),
    .fmul_start(fmul_start),
    .fdiv_start(fdiv_start),
    .itof_res  (ures[0]),
    .ftoi_res  (ures[1]),
    .fadd_res  (ures[2]),
    .fmul_res  (ures[3]),
    .fdiv_res  (ures[4]),
    .res_valid (res_valid),
    .res_tag   (res_tag),
    .res_data  (res_data),
    .res_err   (res_err),
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int div_free = 0;      // first cycle in which a new FDIV may be accepted
  bit dut_ready;         // req_ready as seen in the most recent step

  // Calendar indexed by absolute cycle modulo CAL.
  bit               cap_busy [CAL];
  bit               exp_v    [CAL];
  logic [TAG_W-1:0] exp_tag  [CAL];
  logic [31:0]      exp_data [CAL];
  bit               exp_err  [CAL];
  logic [31:0]      stub_val [5][CAL];
  bit               stub_v   [5][CAL];

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %h expected %h", name, cyc, got, exp);
    end
  endtask

  function automatic int lat_of(input logic [2:0] op);
    case (op)
      3'd0: return LAT_ITOF;
      3'd1: return LAT_FTOI;
      3'd2: return LAT_FADD;
      3'd3: return LAT_FMUL;
      3'd4: return LAT_FDIV;
      default: return 1;
    endcase
  endfunction

  // What each stub unit computes from its operands.
  function automatic logic [31:0] unit_result(input int u, input logic [31:0] a, input logic [31:0] b);
    case (u)
      0: return {a[15:0], a[31:16]} ^ 32'h40E0_0000;
      1: return ~a;
      2: return a + b;
      3: return (a ^ 32'h3F80_0000) + (b << 1);
      4: return (a - b) ^ 32'hD1D1_0000;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_clear();
    for (int k = 0; k < CAL; k++) begin
      cap_busy[k] = 1'b0;
      exp_v[k]    = 1'b0;
      for (int u = 0; u < 5; u++) stub_v[u][k] = 1'b0;
    end
    div_free = 0;
  endtask

  // One clock cycle: drive inputs, check all outputs against the model, update the model.
  task automatic step(input bit rst, input bit v, input logic [2:0] op,
                      input logic [TAG_W-1:0] tag, input logic [31:0] a, input logic [31:0] b);
    int         s;
    int         l;
    int         rc;
    bit         exp_ready;
    bit         fire;
    bit         busy_exp;
    logic [4:0] exp_start;
    @(posedge clk);
    #1;
    cyc++;
    s = cyc % CAL;
    rstn      = !rst;
    req_valid = v && !rst;
    req_op    = op;
    req_tag   = tag;
    req_a     = a;
    req_b     = b;
    if (rst) model_clear();
    for (int u = 0; u < 5; u++) ures[u] = stub_v[u][s] ? stub_val[u][s] : $urandom();
    @(negedge clk);
    l = lat_of(op);
    exp_ready = !cap_busy[(cyc + l) % CAL] && !(op == 3'd4 && cyc < div_free);
    fire      = req_valid && exp_ready;
    exp_start = (fire && op < 3'd5) ? 5'(1 << op) : 5'd0;
    busy_exp  = exp_v[s] || (cyc < div_free);
    for (int k = 0; k < CAL; k++) busy_exp |= cap_busy[k];
    check_eq("req_ready", req_ready, exp_ready);
    check_eq("start", starts, exp_start);
    check_eq("res_valid", res_valid, exp_v[s]);
    if (exp_v[s]) begin
      check_eq("res_tag", res_tag, exp_tag[s]);
      check_eq("res_data", res_data, exp_data[s]);
      check_eq("res_err", res_err, exp_err[s]);
    end
    if (rst) check_eq("rst_res", {res_tag, res_data, res_err}, 64'd0);
    check_eq("busy", busy, busy_exp);
    check_eq("u_ab", {u_a, u_b}, {a, b});
    dut_ready = req_ready;
    // Stub units respond to the strobes they actually see.
    for (int u = 0; u < 5; u++) begin
      if (starts[u]) begin
        rc = (cyc + lat_of(3'(u))) % CAL;
        stub_val[u][rc] = unit_result(u, u_a, u_b);
        stub_v[u][rc]   = 1'b1;
      end
    end
    if (fire) begin
      cap_busy[(cyc + l) % CAL] = 1'b1;
      rc = (cyc + l + 1) % CAL;
      exp_v[rc]    = 1'b1;
      exp_tag[rc]  = tag;
      exp_err[rc]  = (op > 3'd4);
      exp_data[rc] = (op > 3'd4) ? 32'h0 : unit_result(int'(op), a, b);
      if (op == 3'd4) div_free = cyc + l + 1;
    end
    cap_busy[s] = 1'b0;
    exp_v[s]    = 1'b0;
    for (int u = 0; u < 5; u++) stub_v[u][s] = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, '0, 32'h0, 32'h0);
  endtask

  initial begin
    int n;
    logic [2:0] op;
    int r;
    model_clear();
    for (int u = 0; u < 5; u++) ures[u] = '0;
    step(1'b1, 1'b0, 3'd0, '0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 3'd0, '0, 32'h0, 32'h0);
    idle(2);

    // ITOF a=7 tag=3.
    step(1'b0, 1'b1, 3'd0, 4'd3, 32'd7, 32'h0);
    idle(4);

    // FADD then FTOI: FTOI blocked one cycle by the booked writeback slot.
    step(1'b0, 1'b1, 3'd2, 4'd1, 32'h1234_5678, 32'h0101_0101);
    step(1'b0, 1'b1, 3'd1, 4'd9, 32'h0000_00AA, 32'h0);
    check_eq("t2_ftoi_blocked", dut_ready, 1'b0);
    step(1'b0, 1'b1, 3'd1, 4'd9, 32'h0000_00AA, 32'h0);
    check_eq("t2_ftoi_fire", dut_ready, 1'b1);
    idle(4);

    // Back-to-back FMUL tags 0..3.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 3'd3, 4'(i), 32'h100 + 32'(i), 32'h200 + 32'(i));
      check_eq("t3_fmul_ready", dut_ready, 1'b1);
    end
    idle(5);

    // FDIV, FADD behind it, then a second FDIV offered until accepted.
    step(1'b0, 1'b1, 3'd4, 4'd7, 32'hCAFE_0000, 32'h0000_BEEF);
    step(1'b0, 1'b1, 3'd2, 4'd8, 32'h11, 32'h22);
    check_eq("t4_fadd_accept", dut_ready, 1'b1);
    n = 2;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 3'd4, 4'd10, 32'hF00D_0001, 32'h3);
      if (dut_ready) break;
      n++;
    end
    check_eq("t4_fdiv_cycle", n, 9);
    idle(12);

    // Illegal op.
    step(1'b0, 1'b1, 3'd6, 4'd5, 32'hDEAD_BEEF, 32'h1);
    idle(4);

    // Reset with an FDIV in flight; FDIV accepted right after release.
    step(1'b0, 1'b1, 3'd4, 4'd2, 32'h5, 32'h6);
    step(1'b1, 1'b0, 3'd0, '0, 32'h0, 32'h0);
    step(1'b0, 1'b1, 3'd4, 4'd4, 32'h7, 32'h8);
    check_eq("t6_fdiv_after_rst", dut_ready, 1'b1);
    idle(12);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      r  = int'($urandom_range(0, 15));
      op = (r < 14) ? 3'(r % 5) : 3'(5 + $urandom_range(0, 2));
      if ($urandom_range(0, 249) == 0) begin
        step(1'b1, 1'b0, 3'd0, '0, 32'h0, 32'h0);
      end else begin
        step(1'b0, $urandom_range(0, 9) < 7, op, 4'($urandom()), $urandom(), $urandom());
      end
    end
    idle(12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
